duty_button_ctrl: RTL and testbench

Front-panel conditioner that sits directly upstream of the PWM generator. It turns two raw, bouncing push-buttons into clean single-cycle `inc_duty` / `dec_duty` strobes, one strobe per step. Holding a button produces auto-repeat strobes. Pressing both buttons produces a lockout and no strobes. The PWM generator consumes these strobes directly and needs no debounce of its own.

---
 rtl/duty_ctrl_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/duty_button_ctrl.sv | 114 +++++++++++
 tb/tb_duty_button_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_ctrl_pkg.sv
// Shared types and default timing constants for the duty-cycle button conditioner.
package duty_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } duty_state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } duty_dir_e;

  localparam int DEF_DEBOUNCE_CYCLES = 10;
  localparam int DEF_REPEAT_DELAY    = 50;
  localparam int DEF_REPEAT_PERIOD   = 20;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchronizer followed by a disagreement counter that flips the level
// only after DEBOUNCE_CYCLES consecutive cycles of a differing input.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/duty_button_ctrl.sv
// Debounces two buttons and turns them into single-cycle inc/dec strobes with
// auto-repeat; pressing both buttons locks out all strobes until both are released.
module duty_button_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc_raw,
  input  logic       btn_dec_raw,
  output logic       inc_duty,
  output logic       dec_duty,
  output logic       btn_inc_db,
  output logic       btn_dec_db,
  output logic [1:0] state_o
);

  logic             inc_lvl, dec_lvl;
  logic             act_lvl, oth_lvl;
  duty_state_e      state_q, state_d;
  duty_dir_e        dir_q, dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] term_cnt;
  logic             inc_q, inc_d, dec_q, dec_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_inc_raw),
    .level (inc_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_dec_raw),
    .level (dec_lvl)
  );

  assign act_lvl  = (dir_q == DIR_INC) ? inc_lvl : dec_lvl;
  assign oth_lvl  = (dir_q == DIR_INC) ? dec_lvl : inc_lvl;
  assign term_cnt = (state_q == DELAY) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (inc_lvl && dec_lvl) begin
          state_d = LOCK;
        end else if (inc_lvl) begin
          inc_d   = 1'b1;
          dir_d   = DIR_INC;
          state_d = DELAY;
        end else if (dec_lvl) begin
          dec_d   = 1'b1;
          dir_d   = DIR_DEC;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // Lockout and release are checked before expiry so they suppress the strobe.
        if (oth_lvl) begin
          state_d = LOCK;
        end else if (!act_lvl) begin
          state_d = IDLE;
        end else if (timer_q == term_cnt) begin
          inc_d   = (dir_q == DIR_INC);
          dec_d   = (dir_q == DIR_DEC);
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCK: begin
        timer_d = '0;
        if (!inc_lvl && !dec_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_INC;
      timer_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign inc_duty   = inc_q;
  assign dec_duty   = dec_q;
  assign btn_inc_db = inc_lvl;
  assign btn_dec_db = dec_lvl;
  assign state_o    = state_q;

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Directed bench: each scenario task drives the raw buttons and checks levels,
// strobe timing (by cycle index) and FSM state against hand-computed values.
module tb_duty_button_ctrl;
  import duty_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_inc_raw = 1'b0;
  logic       btn_dec_raw = 1'b0;
  logic       inc_duty, dec_duty, btn_inc_db, btn_dec_db;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int inc_log[$];
  int dec_log[$];
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  duty_button_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_inc_raw (btn_inc_raw),
    .btn_dec_raw (btn_dec_raw),
    .inc_duty    (inc_duty),
    .dec_duty    (dec_duty),
    .btn_inc_db  (btn_inc_db),
    .btn_dec_db  (btn_dec_db),
    .state_o     (state_o)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor: logs the cycle index of every strobe, checks exclusivity and width
  always @(posedge clk) begin
    #1;
    if (inc_duty) inc_log.push_back(cyc);
    if (dec_duty) dec_log.push_back(cyc);
    if (inc_duty || dec_duty) begin
      n_cmp++;
      if ((inc_duty && dec_duty) || (inc_duty && prev_inc) || (dec_duty && prev_dec)) begin
        n_fail++;
        $display("FAIL strobe_shape: cyc=%0d inc=%0b dec=%0b prev_inc=%0b prev_dec=%0b required single exclusive pulse",
                 cyc, inc_duty, dec_duty, prev_inc, prev_dec);
      end
    end
    prev_inc = inc_duty;
    prev_dec = dec_duty;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({inc_duty, dec_duty, btn_inc_db, btn_dec_db, state_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {inc_duty, dec_duty, btn_inc_db, btn_dec_db, state_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3);
    n_cmp++;
    if (state_o !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", state_o, IDLE);
    end
  endtask

  task automatic test_glitch;
    int hi;
    hi = 0;
    inc_log.delete(); dec_log.delete();
    btn_inc_raw = 1'b1;
    step(5);
    btn_inc_raw = 1'b0;
    repeat (30) begin
      step(1);
      if (btn_inc_db) hi++;
    end
    n_cmp++;
    if (hi !== 0) begin
      n_fail++;
      $display("FAIL glitch_level: db high %0d cycles required 0", hi);
    end
    n_cmp++;
    if (inc_log.size() + dec_log.size() !== 0) begin
      n_fail++;
      $display("FAIL glitch_strobe: got %0d strobes required 0", inc_log.size() + dec_log.size());
    end
  endtask

  task automatic test_clean_press;
    int c, r;
    inc_log.delete(); dec_log.delete();
    c = cyc;
    btn_inc_raw = 1'b1;
    step(12);
    n_cmp++;
    if (btn_inc_db !== 1'b0) begin
      n_fail++;
      $display("FAIL press_db_early: got %b at edge 11 required 0", btn_inc_db);
    end
    step(1);
    n_cmp++;
    if (btn_inc_db !== 1'b1) begin
      n_fail++;
      $display("FAIL press_db_edge12: got %b required 1", btn_inc_db);
    end
    step(17);
    r = cyc;
    btn_inc_raw = 1'b0;
    step(12);
    n_cmp++;
    if (btn_inc_db !== 1'b1) begin
      n_fail++;
      $display("FAIL release_db_early: got %b required 1", btn_inc_db);
    end
    step(1);
    n_cmp++;
    if (btn_inc_db !== 1'b0) begin
      n_fail++;
      $display("FAIL release_db_edge12: got %b at cyc %0d (release %0d) required 0", btn_inc_db, cyc, r);
    end
    step(5);
    n_cmp++;
    if (inc_log.size() !== 1 || dec_log.size() !== 0) begin
      n_fail++;
      $display("FAIL press_count: got inc=%0d dec=%0d required inc=1 dec=0", inc_log.size(), dec_log.size());
    end else begin
      n_cmp++;
      if (inc_log[0] !== c + 14) begin
        n_fail++;
        $display("FAIL press_latency: strobe at cyc %0d required %0d", inc_log[0], c + 14);
      end
    end
    n_cmp++;
    if (state_o !== IDLE) begin
      n_fail++;
      $display("FAIL press_idle: got state %0d required %0d", state_o, IDLE);
    end
  endtask

  task automatic test_auto_repeat;
    int c, t0;
    int offs[5];
    offs = '{0, 50, 70, 90, 110};
    inc_log.delete(); dec_log.delete();
    c = cyc;
    t0 = c + 14;
    btn_dec_raw = 1'b1;
    step(14 + 107);
    btn_dec_raw = 1'b0;
    step(30);
    n_cmp++;
    if (dec_log.size() !== 5 || inc_log.size() !== 0) begin
      n_fail++;
      $display("FAIL repeat_count: got dec=%0d inc=%0d required dec=5 inc=0", dec_log.size(), inc_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (dec_log[i] !== t0 + offs[i]) begin
          n_fail++;
          $display("FAIL repeat_time%0d: got cyc %0d required %0d", i, dec_log[i], t0 + offs[i]);
        end
      end
    end
  endtask

  task automatic test_lockout;
    int c, c2;
    inc_log.delete(); dec_log.delete();
    c = cyc;
    btn_inc_raw = 1'b1;
    step(24);
    n_cmp++;
    if (state_o !== DELAY) begin
      n_fail++;
      $display("FAIL lock_pre_delay: got state %0d required %0d", state_o, DELAY);
    end
    btn_dec_raw = 1'b1;
    step(100);
    n_cmp++;
    if (state_o !== LOCK) begin
      n_fail++;
      $display("FAIL lock_state: got %0d required %0d", state_o, LOCK);
    end
    n_cmp++;
    if (inc_log.size() !== 1 || dec_log.size() !== 0) begin
      n_fail++;
      $display("FAIL lock_strobes: got inc=%0d dec=%0d required inc=1 dec=0", inc_log.size(), dec_log.size());
    end else begin
      n_cmp++;
      if (inc_log[0] !== c + 14) begin
        n_fail++;
        $display("FAIL lock_first_strobe: got cyc %0d required %0d", inc_log[0], c + 14);
      end
    end
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    step(30);
    n_cmp++;
    if (state_o !== IDLE) begin
      n_fail++;
      $display("FAIL lock_exit: got state %0d required %0d", state_o, IDLE);
    end
    inc_log.delete(); dec_log.delete();
    c2 = cyc;
    btn_dec_raw = 1'b1;
    step(40);
    btn_dec_raw = 1'b0;
    step(30);
    n_cmp++;
    if (dec_log.size() !== 1 || inc_log.size() !== 0) begin
      n_fail++;
      $display("FAIL lock_new_press: got dec=%0d inc=%0d required dec=1 inc=0", dec_log.size(), inc_log.size());
    end else begin
      n_cmp++;
      if (dec_log[0] !== c2 + 14) begin
        n_fail++;
        $display("FAIL lock_new_latency: got cyc %0d required %0d", dec_log[0], c2 + 14);
      end
    end
  endtask

  task automatic test_simultaneous;
    inc_log.delete(); dec_log.delete();
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    step(20);
    n_cmp++;
    if (state_o !== LOCK) begin
      n_fail++;
      $display("FAIL simul_state: got %0d required %0d", state_o, LOCK);
    end
    step(60);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    step(30);
    n_cmp++;
    if (inc_log.size() + dec_log.size() !== 0) begin
      n_fail++;
      $display("FAIL simul_strobes: got %0d required 0", inc_log.size() + dec_log.size());
    end
    n_cmp++;
    if (state_o !== IDLE) begin
      n_fail++;
      $display("FAIL simul_exit: got state %0d required %0d", state_o, IDLE);
    end
  endtask

  task automatic test_reset_mid;
    int c, t0, d;
    inc_log.delete(); dec_log.delete();
    c = cyc;
    t0 = c + 14;
    btn_inc_raw = 1'b1;
    step(14 + 69);
    n_cmp++;
    if (state_o !== REPEAT) begin
      n_fail++;
      $display("FAIL rstmid_repeat: got state %0d required %0d", state_o, REPEAT);
    end
    step(1);
    n_cmp++;
    if (inc_duty !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_strobe70: got %b at cyc %0d required 1 (t0=%0d)", inc_duty, cyc, t0);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({inc_duty, dec_duty, btn_inc_db, btn_dec_db, state_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b required 000000",
               {inc_duty, dec_duty, btn_inc_db, btn_dec_db, state_o});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    inc_log.delete(); dec_log.delete();
    rst_n = 1'b1;
    d = cyc;
    // Release lands so the debounced drop coincides with the second repeat's expiry cycle.
    step(70);
    btn_inc_raw = 1'b0;
    step(30);
    n_cmp++;
    if (inc_log.size() !== 2 || dec_log.size() !== 0) begin
      n_fail++;
      $display("FAIL rstmid_count: got inc=%0d dec=%0d required inc=2 dec=0", inc_log.size(), dec_log.size());
    end else begin
      n_cmp++;
      if (inc_log[0] !== d + 14) begin
        n_fail++;
        $display("FAIL rstmid_first: got cyc %0d required %0d", inc_log[0], d + 14);
      end
      n_cmp++;
      if (inc_log[1] !== d + 64) begin
        n_fail++;
        $display("FAIL rstmid_repeat_time: got cyc %0d required %0d", inc_log[1], d + 64);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_auto_repeat();
    test_lockout();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
